// File: rtl/dft_phase_gen.sv
// -----------------------------------------------------------------------------
// dft_phase_gen
//
// Twiddle-phase sequencer that feeds the CORDIC rotation core of the DFT
// datapath. For one bin index k it emits the N phases theta_n = k*n/N turns,
// n = 0..N-1. The phases leave as a valid/ready stream that carries the sample
// index and a last flag, so the CORDIC stage never has to step through angles
// itself.
//
// Phase words are unsigned turns: a full circle is 2^PHASE_W. The
// accumulator wraps modulo 2^PHASE_W. Bins k >= N/2 therefore alias naturally
// to negative frequencies without any special casing.
//
// Build option (macro QUAD_FOLD_EN):
//   defined   : quad_o  = top two accumulator bits (quadrant 0..3),
//               phase_o = {2'b00, lower PHASE_W-2 bits}. The residual lies in
//               [0, 90deg), inside CORDIC convergence. Downstream applies a
//               quad_o * 90deg post-rotation.
//   undefined : phase_o = raw accumulator (full circle), quad_o = 2'b00.
//   The FSM, handshake and timing are identical in both builds.
//
// Parameters:
//   PHASE_W  phase word width (full circle = 2^PHASE_W)
//   N_LOG2   log2 of the DFT length N; must satisfy N_LOG2 <= PHASE_W-2
//
// Ports:
//   clk_i          in   1        clock, rising edge
//   rst_ni         in   1        synchronous active-low reset
//   start_i        in   1        begin a sequence (only looked at in IDLE)
//   k_i            in   N_LOG2   bin index, captured when start is accepted
//   busy_o         out  1        high in RUN and DONE
//   done_o         out  1        one-cycle pulse after the last beat is taken
//   phase_valid_o  out  1        a phase beat is on the outputs
//   phase_ready_i  in   1        downstream takes the beat
//   phase_o        out  PHASE_W  phase (or residual angle when folding)
//   quad_o         out  2        quadrant code (0 when folding is off)
//   idx_o          out  N_LOG2   sample index n of the current beat
//   last_o         out  1        high on the beat whose index is N-1
//
// Every output is decoded from registers only. phase_ready_i only steers the
// next-state logic, so there is no combinational path from ready to any
// output.
// -----------------------------------------------------------------------------
module dft_phase_gen #(
  parameter int PHASE_W = 16,
  parameter int N_LOG2  = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [N_LOG2-1:0]  k_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               phase_valid_o,
  input  logic               phase_ready_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic [1:0]         quad_o,
  output logic [N_LOG2-1:0]  idx_o,
  output logic               last_o
);

  // The step is k placed so that one unit of k equals 1/N turn.
  localparam int STEP_SHIFT = PHASE_W - N_LOG2;

  localparam logic [N_LOG2-1:0] IDX_LAST = {N_LOG2{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [N_LOG2-1:0]    k_q, k_d;
  logic [PHASE_W-1:0]   acc_q, acc_d;
  logic [N_LOG2-1:0]    idx_q, idx_d;

  logic [PHASE_W-1:0]   step;
  logic                 beat_fire;
  logic                 at_last;

  assign step      = {k_q, {STEP_SHIFT{1'b0}}};
  assign at_last   = (idx_q == IDX_LAST);
  assign beat_fire = (state_q == ST_RUN) && phase_ready_i;

  // ---------------------------------------------------------------------------
  // Next-state / datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    idx_d   = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          k_d     = k_i;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (beat_fire) begin
          if (at_last) begin
            // The final beat's phase and index stay on the outputs. They are
            // harmless because valid drops in DONE.
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            // Wraps modulo 2^PHASE_W. This is how bins above N/2 alias.
            acc_d = acc_q + step;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registers only
  // ---------------------------------------------------------------------------
  assign phase_valid_o = (state_q == ST_RUN);
  assign done_o        = (state_q == ST_DONE);
  assign busy_o        = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign idx_o         = idx_q;
  // Qualified with RUN so that last does not linger into DONE, where idx
  // still holds N-1.
  assign last_o        = (state_q == ST_RUN) && at_last;

`ifdef QUAD_FOLD_EN
  assign quad_o  = acc_q[PHASE_W-1 -: 2];
  assign phase_o = {2'b00, acc_q[PHASE_W-3:0]};
`else
  assign quad_o  = 2'b00;
  assign phase_o = acc_q;
`endif

endmodule
